trp_engine: RTL and testbench
=============================

// Module: trp_engine
// PURPOSE
//  Parametrised transpose/reduction engine for the vector datapath, replacing the
//  reduction-only unit. Accepts LANES-wide vectors. Either reduces each vector to
//  one scalar (SUM/MAX/MIN, pipelined, one per cycle) or collects a LANESxLANES
//  tile and drains it column by column under a read handshake.
// PARAMETERS
//  WIDTH  16  bits per element; signed two's complement
//  LANES  4   elements per vector; power of 2, >=2; also transpose tile dimension
// PORTS
//  clk     in   1            clock, rising edge
//  resetn  in   1            asynchronous active-low reset
//  en      in   1            input beat strobe
//  a       in   LANES*WIDTH  input vector; lane i = a[i*WIDTH +: WIDTH]
//  mode    in   2            00 SUM, 01 MAX, 10 MIN, 11 TRANSPOSE; sampled with en
//  read    in   1            consumer pop of the current transpose column
//  busy    out  1            1 = en is ignored this cycle
//  valid   out  1            out holds a result
//  out     out  LANES*WIDTH  result vector
// BEHAVIOUR
//  Reset: busy=0, valid=0, out=0. Tile, counters and pipeline are cleared; FSM->IDLE.
//   Reset mid-fill or mid-drain discards the tile and any in-flight results.
//  Accept: a beat is accepted when en && !busy. The rules below also apply.
//  Reduction (mode!=11)
//   - Accepted in IDLE only. In FILL a beat with en && mode!=11 is dropped silently.
//   - Two-stage pipeline: input register, then reduce and output register.
//     Accept at cycle t -> valid=1 for exactly one cycle at t+2.
//   - Back-to-back accepts give back-to-back valid pulses. Reduction never raises busy.
//   - SUM: sum of all lanes modulo 2^WIDTH, wrap with no saturation.
//   - MAX / MIN: signed compare. Ties have no visible effect.
//   - Result goes on lane 0. Lanes 1..LANES-1 are driven 0. read is ignored.
//  Transpose FSM: IDLE -> FILL -> DRAIN -> IDLE
//   - IDLE: an accepted beat with mode=11 writes row 0 and moves to FILL (row_cnt=1).
//   - FILL: each accepted mode=11 beat writes row row_cnt.
//     Writing row LANES-1 moves to DRAIN with col_cnt=0.
//   - DRAIN: busy=1 and valid=1, held until the last column is read.
//     out lane j = tile[row j][col_cnt].
//     read=1 advances col_cnt. read of column LANES-1 returns to IDLE.
//     In the next cycle busy=0 and valid=0.
//     Without read, out and valid hold indefinitely.
//   - First column is valid the cycle after the last row is accepted.
//   - busy=1 only in DRAIN. en in the cycle of the final read is ignored.
//  Output mux: DRAIN has the tile column; otherwise the reduction stage-2 register.
//   No collision is possible. Reductions accepted before the first row drain by t+2.
//   DRAIN starts no earlier than first-row+LANES, which is >= t+2.
//  out is 0 whenever valid=0.
//  read outside DRAIN has no effect. mode is ignored when en=0.
// TESTING (WIDTH=16, LANES=4)
//  1 SUM a={4,3,2,1}, then MAX {-5,7,7,0}, then MIN {-5,7,7,0} on consecutive cycles.
//    -> valid pulses on 3 consecutive cycles, each 2 after its accept.
//    -> lane0 = 10, 7, -5; other lanes 0.
//  2 SUM {0x7FFF,1,0,0} -> lane0=0x8000 (wrap). MIN {0x8000,0x7FFF,0,0} -> lane0=0x8000.
//  3 Transpose: rows r=0..3 with lane c = r*4+c.
//    -> busy=1 the cycle after row 3; column 0 out = {12,8,4,0} (lane3..lane0).
//    -> read held 1 for 4 cycles gives columns {12,8,4,0},{13,9,5,1},{14,10,6,2},{15,11,7,3}.
//    -> then busy=0, valid=0.
//  4 In DRAIN, hold read=0 for 10 cycles while pulsing en with SUM.
//    -> column 0 stable, en ignored, no reduction valid.
//    -> SUM issued during FILL is dropped (no pulse).
//  5 SUM accepted, next cycle first transpose row.
//    -> reduction valid at t+2 during FILL; tile drains correctly afterwards.
//  6 Assert resetn=0 after 2 rows, or mid-drain after 1 read.
//    -> immediately busy=0, valid=0, out=0.
//    -> a fresh 4-row fill afterwards drains only new data.

Source files
------------

// File: rtl/trp_engine.sv
// rtl/trp_engine.sv - transpose/reduction engine for LANES-wide signed vectors
module trp_engine #(
   parameter int WIDTH = 16,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   en,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [1:0]             mode,
   input  logic                   read,
   output logic                   busy,
   output logic                   valid,
   output logic [LANES*WIDTH-1:0] out
);

   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   state_t           state;
   logic [CW-1:0]    row_cnt;
   logic [CW-1:0]    col_cnt;
   logic [WIDTH-1:0] tile [LANES][LANES];

   logic                   s1_valid;
   logic [1:0]             s1_mode;
   logic [LANES*WIDTH-1:0] s1_data;
   logic                   s2_valid;
   logic [WIDTH-1:0]       s2_res;
   logic [WIDTH-1:0]       red_res;
   logic [WIDTH-1:0]       lane;

   logic accept;
   logic red_accept;
   logic row_accept;

   assign accept     = en && !busy;
   assign red_accept = accept && (mode != 2'b11) && (state == IDLE);
   assign row_accept = accept && (mode == 2'b11) && (state != DRAIN);

   // Stage 1: capture the vector and operation of an accepted reduction beat
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_mode  <= 2'b00;
         s1_data  <= '0;
      end else begin
         s1_valid <= red_accept;
         if (red_accept) begin
            s1_mode <= mode;
            s1_data <= a;
         end
      end
   end

   // Fold all lanes into one scalar: wrapping sum or signed max/min
   always_comb begin
      red_res = s1_data[WIDTH-1:0];
      lane    = '0;
      for (int i = 1; i < LANES; i++) begin
         lane = s1_data[i*WIDTH +: WIDTH];
         case (s1_mode)
            2'b00:   red_res = red_res + lane;
            2'b01:   if ($signed(lane) > $signed(red_res)) red_res = lane;
            default: if ($signed(lane) < $signed(red_res)) red_res = lane;
         endcase
      end
   end

   // Stage 2: result register, kept at zero when no result is present
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s2_valid <= 1'b0;
         s2_res   <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_res   <= s1_valid ? red_res : '0;
      end
   end

   // Transpose FSM: fill rows, then drain columns under the read handshake
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         row_cnt <= '0;
         col_cnt <= '0;
         busy    <= 1'b0;
         for (int r = 0; r < LANES; r++) begin
            for (int c = 0; c < LANES; c++) begin
               tile[r][c] <= '0;
            end
         end
      end else begin
         if (row_accept) begin
            for (int c = 0; c < LANES; c++) begin
               tile[row_cnt][c] <= a[c*WIDTH +: WIDTH];
            end
            row_cnt <= row_cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               if (row_accept) state <= FILL;
            end
            FILL: begin
               if (row_accept && row_cnt == CW'(LANES-1)) begin
                  state   <= DRAIN;
                  col_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            DRAIN: begin
               if (read) begin
                  col_cnt <= col_cnt + 1'b1;
                  if (col_cnt == CW'(LANES-1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               row_cnt <= '0;
            end
         endcase
      end
   end

   // Output select: tile column while draining, otherwise the reduction result
   always_comb begin
      out   = '0;
      valid = s2_valid;
      if (state == DRAIN) begin
         valid = 1'b1;
         for (int j = 0; j < LANES; j++) begin
            out[j*WIDTH +: WIDTH] = tile[j][col_cnt];
         end
      end else begin
         out[WIDTH-1:0] = s2_res;
      end
   end

endmodule

// File: tb/tb_trp_engine.sv
// tb/tb_trp_engine.sv - randomized self-checking bench for trp_engine
module tb_trp_engine;

   localparam int W = 16;
   localparam int L = 4;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           en = 1'b0;
   logic [L*W-1:0] a = '0;
   logic [1:0]     mode = 2'b00;
   logic           read = 1'b0;
   logic           busy;
   logic           valid;
   logic [L*W-1:0] out;

   trp_engine #(.WIDTH(W), .LANES(L)) dut (
      .clk(clk), .resetn(resetn), .en(en), .a(a), .mode(mode),
      .read(read), .busy(busy), .valid(valid), .out(out)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: phase 0 idle, 1 collecting rows, 2 draining
   int          phase = 0;
   int          rows = 0;
   int          col = 0;
   int          tile_m [L][L];
   logic        sv [8];
   logic [W-1:0] sr [8];
   int          cyc = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int lane_of(input logic [L*W-1:0] v, input int c);
      return int'($signed(v[c*W +: W]));
   endfunction

   function automatic logic [L*W-1:0] row_vec(input int r);
      logic [L*W-1:0] v;
      for (int c = 0; c < L; c++) v[c*W +: W] = W'(r*L + c);
      return v;
   endfunction

   function automatic logic [L*W-1:0] pack4(input int l3, input int l2, input int l1, input int l0);
      return {W'(l3), W'(l2), W'(l1), W'(l0)};
   endfunction

   // One clock cycle: check the current outputs, advance the model, drive inputs
   task automatic step(input logic e, input logic [1:0] m, input logic [L*W-1:0] av, input logic rd);
      logic           ev, eb;
      logic [L*W-1:0] eo;
      int             s, best;
      @(negedge clk);
      eo = '0;
      if (phase == 2) begin
         ev = 1'b1;
         eb = 1'b1;
         for (int j = 0; j < L; j++) eo[j*W +: W] = W'(tile_m[j][col]);
      end else begin
         eb = 1'b0;
         ev = sv[cyc % 8];
         if (ev) eo[W-1:0] = sr[cyc % 8];
      end
      chk("busy", {63'b0, busy}, {63'b0, eb});
      chk("valid", {63'b0, valid}, {63'b0, ev});
      chk("out", out, eo);
      sv[cyc % 8] = 1'b0;

      if (phase == 2) begin
         if (rd) begin
            col++;
            if (col == L) begin
               phase = 0;
               col = 0;
            end
         end
      end else if (e) begin
         if (m == 2'b11) begin
            for (int c = 0; c < L; c++) tile_m[rows][c] = lane_of(av, c);
            rows++;
            phase = 1;
            if (rows == L) begin
               phase = 2;
               rows = 0;
               col = 0;
            end
         end else if (phase == 0) begin
            s = 0;
            best = lane_of(av, 0);
            for (int c = 0; c < L; c++) begin
               s += lane_of(av, c);
               if (m == 2'b01 && lane_of(av, c) > best) best = lane_of(av, c);
               if (m == 2'b10 && lane_of(av, c) < best) best = lane_of(av, c);
            end
            sv[(cyc + 2) % 8] = 1'b1;
            sr[(cyc + 2) % 8] = (m == 2'b00) ? W'(s) : W'(best);
         end
      end
      en = e;
      mode = m;
      a = av;
      read = rd;
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      en = 1'b0;
      read = 1'b0;
      #1;
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_valid", {63'b0, valid}, 64'd0);
      chk("rst_out", out, 64'd0);
      phase = 0;
      rows = 0;
      col = 0;
      for (int i = 0; i < 8; i++) sv[i] = 1'b0;
      @(posedge clk);
      #2 resetn = 1'b1;
   endtask

   task automatic fill_rows(input int base);
      for (int r = 0; r < L; r++) step(1'b1, 2'b11, row_vec(r + base), 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         sv[i] = 1'b0;
         sr[i] = '0;
      end
      do_reset();

      // 1: back-to-back SUM / MAX / MIN
      step(1'b1, 2'b00, pack4(4, 3, 2, 1), 1'b0);
      step(1'b1, 2'b01, pack4(-5, 7, 7, 0), 1'b0);
      step(1'b1, 2'b10, pack4(-5, 7, 7, 0), 1'b0);
      chk("t1_sum", out, 64'd10);
      step(1'b0, 2'b00, '0, 1'b0);
      chk("t1_max", out, 64'd7);
      step(1'b0, 2'b00, '0, 1'b0);
      chk("t1_min", out, 64'h0000_0000_0000_FFFB);
      step(1'b0, 2'b00, '0, 1'b0);

      // 2: wrap and signed extreme
      step(1'b1, 2'b00, pack4(0, 0, 1, 16'h7FFF), 1'b0);
      step(1'b1, 2'b10, pack4(0, 0, 16'h7FFF, 16'h8000), 1'b0);
      step(1'b0, 2'b00, '0, 1'b0);
      chk("t2_wrap", out, 64'h8000);
      step(1'b0, 2'b00, '0, 1'b0);
      chk("t2_min", out, 64'h8000);

      // 3: transpose drain with read held high
      fill_rows(0);
      step(1'b0, 2'b00, '0, 1'b1);
      chk("t3_col0", out, 64'h000C_0008_0004_0000);
      step(1'b0, 2'b00, '0, 1'b1);
      chk("t3_col1", out, 64'h000D_0009_0005_0001);
      step(1'b0, 2'b00, '0, 1'b1);
      chk("t3_col2", out, 64'h000E_000A_0006_0002);
      step(1'b0, 2'b00, '0, 1'b1);
      chk("t3_col3", out, 64'h000F_000B_0007_0003);
      step(1'b0, 2'b00, '0, 1'b0);
      chk("t3_done", {62'b0, busy, valid}, 64'd0);

      // 4: SUM dropped in FILL, en ignored while stalled in DRAIN
      step(1'b1, 2'b11, row_vec(20), 1'b0);
      step(1'b1, 2'b00, pack4(1, 1, 1, 1), 1'b0);
      for (int r = 1; r < L; r++) step(1'b1, 2'b11, row_vec(20 + r), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 2'b00, pack4(i, 1, 2, 3), 1'b0);
      for (int i = 0; i < L; i++) step(1'b1, 2'b00, '0, 1'b1);

      // 5: reduction overlapping the start of a fill
      step(1'b1, 2'b01, pack4(9, -3, 2, 5), 1'b0);
      fill_rows(40);
      for (int i = 0; i < L + 1; i++) step(1'b0, 2'b00, '0, 1'b1);

      // 6: reset mid-fill and mid-drain, then fresh tiles
      step(1'b1, 2'b11, row_vec(60), 1'b0);
      step(1'b1, 2'b11, row_vec(61), 1'b0);
      do_reset();
      fill_rows(80);
      for (int i = 0; i < L + 1; i++) step(1'b0, 2'b00, '0, 1'b1);
      fill_rows(100);
      step(1'b0, 2'b00, '0, 1'b1);
      step(1'b0, 2'b00, '0, 1'b0);
      do_reset();
      fill_rows(120);
      for (int i = 0; i < L + 1; i++) step(1'b0, 2'b00, '0, 1'b1);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 2) != 0,
                 ($urandom_range(0, 9) < 4) ? 2'b11 : 2'($urandom_range(0, 2)),
                 {$urandom, $urandom},
                 $urandom_range(0, 2) == 0);
         end
      end
      step(1'b0, 2'b00, '0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
